crc_stim_check: RTL and testbench

- Self-checking stimulus/response stage wrapped around a small combinational DUT in a regression test.
- Upstream role: a 64-bit LFSR ("CRC") generates a pseudo-random stimulus bit each cycle, which drives the DUT input.
- Downstream role: it folds the DUT outputs into a 64-bit signature over a fixed run window. At the end of the run it compares both registers against expected constants and reports pass or fail.

---
 rtl/crc_stim_check.sv | 132 +++++++++++++
 tb/tb_crc_stim_check.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/crc_stim_check.sv
// Stimulus/response checker: a 64-bit LFSR drives the DUT input bit, and the DUT outputs are
// folded into a 64-bit signature that is compared against golden constants at the end of a run.
module crc_stim_check #(
    parameter int unsigned OBS_W   = 2,
    parameter int unsigned CYCLES  = 99,
    parameter int unsigned WARM    = 10,
    parameter logic [63:0] SEED    = 64'h5aef0c8d_d70a4497,
    parameter logic [63:0] EXP_CRC = 64'h0,
    parameter logic [63:0] EXP_SUM = 64'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OBS_W-1:0] obs,
    output logic             stim,
    output logic [63:0]      crc_o,
    output logic [63:0]      sum_o,
    output logic [31:0]      cyc_o,
    output logic             done,
    output logic             pass,
    output logic             fail
);

    generate
        if (WARM < 32'd1 || WARM >= CYCLES || CYCLES >= 32'hFFFF_FFFF ||
            OBS_W < 32'd1 || OBS_W > 32'd64) begin : g_param_check
            $error("crc_stim_check: illegal parameters (need 1<=WARM<CYCLES<2^32-1, 1<=OBS_W<=64)");
        end
    endgenerate

    typedef enum logic [2:0] {PhInit, PhWarm, PhRun, PhCheck, PhDone} phase_e;

    function automatic logic [63:0] lfsr(input logic [63:0] x);
        return {x[62:0], x[63] ^ x[2] ^ x[0]};
    endfunction

    logic [31:0] r_cyc;
    logic [63:0] r_crc;
    logic [63:0] r_sum;
    logic        r_done;
    logic        r_pass;
    logic        r_fail;

    logic [31:0] w_cyc_nxt;
    logic [63:0] w_crc_nxt;
    logic [63:0] w_sum_nxt;
    logic        w_done_nxt;
    logic        w_pass_nxt;
    logic        w_fail_nxt;
    logic [63:0] w_obs_ext;
    logic        w_match;
    phase_e      w_phase;

    assign w_obs_ext = 64'(obs);
    assign w_match   = (r_crc == EXP_CRC) && (r_sum == EXP_SUM);

    // Phase is a pure decode of the counter; the counter parks at CYCLES+1 once done is set.
    always_comb begin
        w_phase = PhCheck;
        if (r_done) begin
            w_phase = PhDone;
        end else if (r_cyc == 32'd0) begin
            w_phase = PhInit;
        end else if (r_cyc < WARM) begin
            w_phase = PhWarm;
        end else if (r_cyc < CYCLES) begin
            w_phase = PhRun;
        end
    end

    always_comb begin
        w_cyc_nxt  = r_cyc;
        w_crc_nxt  = r_crc;
        w_sum_nxt  = r_sum;
        w_done_nxt = r_done;
        w_pass_nxt = r_pass;
        w_fail_nxt = r_fail;
        unique case (w_phase)
            PhInit: begin
                w_cyc_nxt = r_cyc + 32'd1;
                w_crc_nxt = SEED;
                w_sum_nxt = 64'd0;
            end
            PhWarm: begin
                w_cyc_nxt = r_cyc + 32'd1;
                w_crc_nxt = lfsr(r_crc);
                w_sum_nxt = 64'd0;
            end
            PhRun: begin
                w_cyc_nxt = r_cyc + 32'd1;
                w_crc_nxt = lfsr(r_crc);
                w_sum_nxt = lfsr(r_sum) ^ w_obs_ext;
            end
            PhCheck: begin
                w_cyc_nxt  = r_cyc + 32'd1;
                w_done_nxt = 1'b1;
                w_pass_nxt = w_match;
                w_fail_nxt = !w_match;
            end
            PhDone: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc  <= 32'd0;
            r_crc  <= 64'd0;
            r_sum  <= 64'd0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else begin
            r_cyc  <= w_cyc_nxt;
            r_crc  <= w_crc_nxt;
            r_sum  <= w_sum_nxt;
            r_done <= w_done_nxt;
            r_pass <= w_pass_nxt;
            r_fail <= w_fail_nxt;
        end
    end

    assign stim  = r_crc[0];
    assign crc_o = r_crc;
    assign sum_o = r_sum;
    assign cyc_o = r_cyc;
    assign done  = r_done;
    assign pass  = r_pass;
    assign fail  = r_fail;

endmodule

// File: tb/tb_crc_stim_check.sv
// Bench for crc_stim_check: vector table on small-window instances, hand-written reset/freeze
// sequences, a random-obs run against a history-based model, and a default-size golden run.
module tb_crc_stim_check;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [63:0] lfsr(input logic [63:0] x);
        return {x[62:0], x[63] ^ x[2] ^ x[0]};
    endfunction

    // Golden run for the default parameters with a DUT where a=b=c, obs={a,b}, c=stim.
    function automatic logic [127:0] golden_default();
        logic [63:0] c;
        logic [63:0] s;
        c = 64'h5aef0c8d_d70a4497;
        s = 64'd0;
        for (int k = 1; k < 99; k++) begin
            if (k >= 10) s = lfsr(s) ^ {62'd0, c[0], c[0]};
            c = lfsr(c);
        end
        return {c, s};
    endfunction

    localparam logic [127:0] GOLD     = golden_default();
    localparam logic [63:0]  GOLD_CRC = GOLD[127:64];
    localparam logic [63:0]  GOLD_SUM = GOLD[63:0];

    localparam int unsigned R_CYC  = 40;
    localparam int unsigned R_WARM = 5;
    localparam logic [63:0] R_SEED = 64'h0123_4567_89ab_cdef;

    // Small-window instances share reset and obs.
    logic       rst_s;
    logic [1:0] obs_s;
    logic        stim_a, stim_b, stim_c;
    logic [63:0] crc_a, crc_b, crc_c, sum_a, sum_b, sum_c;
    logic [31:0] cyc_a, cyc_b, cyc_c;
    logic        done_a, done_b, done_c, pass_a, pass_b, pass_c, fail_a, fail_b, fail_c;

    crc_stim_check #(.OBS_W(2), .CYCLES(4), .WARM(2), .SEED(64'd1),
                     .EXP_CRC(64'hE), .EXP_SUM(64'd0)) u_a (
        .clk(clk), .reset(rst_s), .obs(obs_s), .stim(stim_a), .crc_o(crc_a), .sum_o(sum_a),
        .cyc_o(cyc_a), .done(done_a), .pass(pass_a), .fail(fail_a));

    crc_stim_check #(.OBS_W(2), .CYCLES(4), .WARM(2), .SEED(64'd1),
                     .EXP_CRC(64'hE), .EXP_SUM(64'd2)) u_b (
        .clk(clk), .reset(rst_s), .obs(obs_s), .stim(stim_b), .crc_o(crc_b), .sum_o(sum_b),
        .cyc_o(cyc_b), .done(done_b), .pass(pass_b), .fail(fail_b));

    crc_stim_check #(.OBS_W(2), .CYCLES(4), .WARM(2), .SEED(64'd1),
                     .EXP_CRC(64'hF), .EXP_SUM(64'd0)) u_c (
        .clk(clk), .reset(rst_s), .obs(obs_s), .stim(stim_c), .crc_o(crc_c), .sum_o(sum_c),
        .cyc_o(cyc_c), .done(done_c), .pass(pass_c), .fail(fail_c));

    logic        rst_d;
    logic        stim_d, done_d, pass_d, fail_d;
    logic [63:0] crc_d, sum_d;
    logic [31:0] cyc_d;
    logic [1:0]  obs_d;
    assign obs_d = {stim_d, stim_d};

    crc_stim_check #(.EXP_CRC(GOLD_CRC), .EXP_SUM(GOLD_SUM)) u_d (
        .clk(clk), .reset(rst_d), .obs(obs_d), .stim(stim_d), .crc_o(crc_d), .sum_o(sum_d),
        .cyc_o(cyc_d), .done(done_d), .pass(pass_d), .fail(fail_d));

    logic        rst_r;
    logic [7:0]  obs_r;
    logic        stim_r, done_r, pass_r, fail_r;
    logic [63:0] crc_r, sum_r;
    logic [31:0] cyc_r;

    crc_stim_check #(.OBS_W(8), .CYCLES(R_CYC), .WARM(R_WARM), .SEED(R_SEED),
                     .EXP_CRC(64'd0), .EXP_SUM(64'd0)) u_r (
        .clk(clk), .reset(rst_r), .obs(obs_r), .stim(stim_r), .crc_o(crc_r), .sum_o(sum_r),
        .cyc_o(cyc_r), .done(done_r), .pass(pass_r), .fail(fail_r));

    typedef struct {
        logic [1:0]  obs;
        logic [31:0] cyc;
        logic [63:0] crc;
        logic [63:0] sum;
        logic        done, pass, fail, b_pass, c_fail;
    } vec_t;

    vec_t tbl[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [63:0] e_crc, e_sum;
        logic        e_done, e_ok, prev_stim;
        int          m_cyc, toggles, steps;
        logic [7:0]  hist[$];

        rst_s = 1'b1; rst_d = 1'b1; rst_r = 1'b1;
        obs_s = 2'd0; obs_r = 8'd0;

        //          obs   cyc    crc    sum   done pass fail bpass cfail
        tbl[0]  = '{2'd0, 32'd1, 64'h1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2'd0, 32'd2, 64'h3, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{2'd0, 32'd3, 64'h7, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{2'd0, 32'd4, 64'hE, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{2'd0, 32'd5, 64'hE, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{2'd0, 32'd5, 64'hE, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{2'd1, 32'd1, 64'h1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{2'd1, 32'd2, 64'h3, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{2'd1, 32'd3, 64'h7, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{2'd1, 32'd4, 64'hE, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{2'd1, 32'd5, 64'hE, 64'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{2'd1, 32'd5, 64'hE, 64'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        for (int i = 0; i < 12; i++) begin
            if (i % 6 == 0) begin
                rst_s = 1'b1;
                obs_s = tbl[i].obs;
                for (int h = 0; h < 3; h++) begin
                    tick();
                    check($sformatf("reset_hold%0d", i / 6),
                          {cyc_a, crc_a, sum_a, stim_a, done_a, pass_a, fail_a}, 256'd0);
                end
                rst_s = 1'b0;
            end
            tick();
            check($sformatf("vec%0d", i),
                  {cyc_a, crc_a, sum_a, stim_a, done_a, pass_a, fail_a, pass_b, fail_c},
                  {tbl[i].cyc, tbl[i].crc, tbl[i].sum, tbl[i].crc[0], tbl[i].done,
                   tbl[i].pass, tbl[i].fail, tbl[i].b_pass, tbl[i].c_fail});
        end

        // Frozen after done: u_c has failed with obs=1; random obs must not move anything.
        for (int k = 0; k < 20; k++) begin
            obs_s = 2'($urandom);
            tick();
            check($sformatf("freeze%0d", k), {cyc_c, crc_c, sum_c, done_c, pass_c, fail_c},
                  {32'd5, 64'hE, 64'd2, 1'b1, 1'b0, 1'b1});
        end

        // Mid-run reset at cyc=3, then a clean rerun must pass.
        obs_s = 2'd0;
        rst_s = 1'b1; tick(); rst_s = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("midrun_pre", {cyc_a, crc_a}, {32'd3, 64'h7});
        rst_s = 1'b1; tick(); rst_s = 1'b0;
        check("midrun_reset", {cyc_a, crc_a, sum_a, done_a}, 256'd0);
        for (int k = 0; k < 5; k++) tick();
        check("rerun_pass", {cyc_a, crc_a, done_a, pass_a, fail_a}, {32'd5, 64'hE, 3'b110});

        // Reset coinciding with the check edge: reset wins.
        rst_s = 1'b1; tick(); rst_s = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("pre_check", {cyc_a, done_a}, {32'd4, 1'b0});
        rst_s = 1'b1; tick(); rst_s = 1'b0;
        check("reset_at_check", {cyc_a, crc_a, done_a, pass_a, fail_a}, 256'd0);

        // Random obs and random resets against a history-based model.
        m_cyc = 0;
        for (int k = 0; k < 400; k++) begin
            rst_r = (k == 0) || (k > 50 && $urandom_range(0, 60) == 0);
            obs_r = 8'($urandom);
            if (rst_r) begin
                m_cyc = 0;
                hist.delete();
            end else if (m_cyc <= int'(R_CYC)) begin
                if (m_cyc >= int'(R_WARM) && m_cyc < int'(R_CYC)) hist.push_back(obs_r);
                m_cyc++;
            end
            tick();
            e_crc = 64'd0;
            if (m_cyc >= 1) begin
                e_crc = R_SEED;
                steps = (m_cyc > int'(R_CYC)) ? int'(R_CYC) - 1 : m_cyc - 1;
                for (int s = 0; s < steps; s++) e_crc = lfsr(e_crc);
            end
            e_sum = 64'd0;
            foreach (hist[j]) e_sum = lfsr(e_sum) ^ 64'(hist[j]);
            e_done = (m_cyc == int'(R_CYC) + 1);
            e_ok   = (e_crc == 64'd0) && (e_sum == 64'd0);
            check($sformatf("rand%0d", k),
                  {cyc_r, crc_r, sum_r, stim_r, done_r, pass_r, fail_r},
                  {32'(m_cyc), e_crc, e_sum, e_crc[0], e_done, e_done && e_ok, e_done && !e_ok});
        end

        // Default-size run with the a=b=c DUT on obs.
        rst_d = 1'b1; tick(); rst_d = 1'b0;
        toggles = 0;
        prev_stim = stim_d;
        for (int k = 0; k < 200 && !done_d; k++) begin
            tick();
            if (stim_d != prev_stim) toggles++;
            prev_stim = stim_d;
        end
        check("dflt_done", {done_d, pass_d, fail_d, cyc_d}, {3'b110, 32'd100});
        check("dflt_sig", {crc_d, sum_d}, {GOLD_CRC, GOLD_SUM});
        check("dflt_toggle", 256'(toggles > 10), 256'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
